// File: rtl/chroma_recon_if.sv
// Row bus of the chroma reconstruction block: residual/prediction rows in,
// reconstructed rows with block/row labels and column feedback bytes out.
interface chroma_recon_if;
    logic        NEWLINE;
    logic        STROBEI;
    logic [35:0] DATAI;
    logic [31:0] BASEI;
    logic        STROBEO;
    logic [31:0] DATAO;
    logic [2:0]  XXO;
    logic [1:0]  ROWO;
    logic        MBDONE;
    logic        FBSTROBE;
    logic [7:0]  FEEDBO;
    logic [2:0]  FBXX;

    modport master (
        output NEWLINE, STROBEI, DATAI, BASEI,
        input  STROBEO, DATAO, XXO, ROWO, MBDONE, FBSTROBE, FEEDBO, FBXX
    );

    modport slave (
        input  NEWLINE, STROBEI, DATAI, BASEI,
        output STROBEO, DATAO, XXO, ROWO, MBDONE, FBSTROBE, FEEDBO, FBXX
    );
endinterface

// File: rtl/chroma_recon.sv
// Chroma reconstruction: prediction + residual clipped to 8 bits, rows labelled by
// block/row, and each block's rightmost column drained as four feedback bytes.
module chroma_recon #(
    parameter bit FBEN = 1'b1
) (
    input logic           CLK2,
    input logic           RESET,
    chroma_recon_if.slave bus
);
    typedef enum logic {DR_IDLE, DR_EMIT} drain_state_e;

    logic signed [9:0] lane_sum;
    logic [31:0]       clip_row;
    logic              accept;
    logic              abort_drain;
    logic              load_drain;
    logic              emit;
    logic [1:0]        lbl_row;
    logic [2:0]        lbl_blk;

    logic [1:0]   row_cnt_q, row_cnt_d;
    logic [2:0]   blk_cnt_q, blk_cnt_d;
    logic         strobe_q, strobe_d;
    logic [31:0]  data_q, data_d;
    logic [2:0]   xx_q, xx_d;
    logic [1:0]   row_q, row_d;
    logic         mbdone_q, mbdone_d;
    logic [7:0]   col_q [4];
    logic [7:0]   col_d [4];
    logic [31:0]  drain_q, drain_d;
    logic [2:0]   drain_xx_q, drain_xx_d;
    drain_state_e state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic         fbstrobe_q, fbstrobe_d;
    logic [7:0]   feedbo_q, feedbo_d;
    logic [2:0]   fbxx_q, fbxx_d;

    // Per lane the 10-bit signed sum spans -256..510, so bit 9 flags underflow and bit 8 overflow.
    always_comb begin
        clip_row = '0;
        lane_sum = '0;
        for (int k = 0; k < 4; k++) begin
            lane_sum = $signed({2'b00, bus.BASEI[8*k +: 8]})
                     + $signed({bus.DATAI[9*k+8], bus.DATAI[9*k +: 9]});
            if (lane_sum[9])
                clip_row[8*k +: 8] = 8'h00;
            else if (lane_sum[8])
                clip_row[8*k +: 8] = 8'hFF;
            else
                clip_row[8*k +: 8] = lane_sum[7:0];
        end
    end

    // A NEWLINE arriving with a row makes that row block 0 row 0.
    assign accept      = bus.STROBEI;
    assign abort_drain = bus.NEWLINE && !bus.STROBEI;
    assign lbl_row     = bus.NEWLINE ? 2'd0 : row_cnt_q;
    assign lbl_blk     = bus.NEWLINE ? 3'd0 : blk_cnt_q;
    assign load_drain  = accept && (lbl_row == 2'd3);

    always_comb begin
        row_cnt_d = row_cnt_q;
        blk_cnt_d = blk_cnt_q;
        if (accept) begin
            row_cnt_d = lbl_row + 2'd1;
            blk_cnt_d = (lbl_row == 2'd3) ? lbl_blk + 3'd1 : lbl_blk;
        end else if (bus.NEWLINE) begin
            row_cnt_d = 2'd0;
            blk_cnt_d = 3'd0;
        end
    end

    always_comb begin
        strobe_d   = accept;
        data_d     = data_q;
        xx_d       = xx_q;
        row_d      = row_q;
        mbdone_d   = accept && (lbl_blk == 3'd7) && (lbl_row == 2'd3);
        col_d      = col_q;
        drain_d    = drain_q;
        drain_xx_d = drain_xx_q;
        if (accept) begin
            data_d         = clip_row;
            xx_d           = lbl_blk;
            row_d          = lbl_row;
            col_d[lbl_row] = clip_row[31:24];
        end
        // Row 3 bypasses the column buffer so the buffer is free for the next block at once.
        if (load_drain) begin
            drain_d    = {clip_row[31:24], col_q[2], col_q[1], col_q[0]};
            drain_xx_d = lbl_blk;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (load_drain) begin
            state_d = DR_EMIT;
            idx_d   = 2'd0;
        end else if (abort_drain) begin
            state_d = DR_IDLE;
        end else if (state_q == DR_EMIT) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3)
                state_d = DR_IDLE;
        end
    end

    // Feedback outputs are registered, so a back-to-back reload still emits the old byte 3.
    always_comb begin
        emit       = (state_q == DR_EMIT) && !abort_drain;
        fbstrobe_d = FBEN && emit;
        feedbo_d   = emit ? drain_q[8*idx_q +: 8] : feedbo_q;
        fbxx_d     = emit ? drain_xx_q : fbxx_q;
    end

    always_ff @(posedge CLK2) begin
        if (RESET) begin
            state_q <= DR_IDLE;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge CLK2) begin
        if (RESET) begin
            row_cnt_q  <= '0;
            blk_cnt_q  <= '0;
            strobe_q   <= 1'b0;
            data_q     <= '0;
            xx_q       <= '0;
            row_q      <= '0;
            mbdone_q   <= 1'b0;
            drain_q    <= '0;
            drain_xx_q <= '0;
            fbstrobe_q <= 1'b0;
            feedbo_q   <= '0;
            fbxx_q     <= '0;
            for (int i = 0; i < 4; i++)
                col_q[i] <= '0;
        end else begin
            row_cnt_q  <= row_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
            strobe_q   <= strobe_d;
            data_q     <= data_d;
            xx_q       <= xx_d;
            row_q      <= row_d;
            mbdone_q   <= mbdone_d;
            drain_q    <= drain_d;
            drain_xx_q <= drain_xx_d;
            fbstrobe_q <= fbstrobe_d;
            feedbo_q   <= feedbo_d;
            fbxx_q     <= fbxx_d;
            col_q      <= col_d;
        end
    end

    assign bus.STROBEO  = strobe_q;
    assign bus.DATAO    = data_q;
    assign bus.XXO      = xx_q;
    assign bus.ROWO     = row_q;
    assign bus.MBDONE   = mbdone_q;
    assign bus.FBSTROBE = fbstrobe_q;
    assign bus.FEEDBO   = feedbo_q;
    assign bus.FBXX     = fbxx_q;
endmodule

// File: tb/tb_chroma_recon.sv
// Bench for chroma_recon: directed scenarios plus random rows checked against a
// row-level model that tracks labels, clipping and the feedback byte schedule.
module tb_chroma_recon;
    logic CLK2 = 1'b0;
    logic RESET;

    chroma_recon_if bus();

    chroma_recon #(.FBEN(1'b1)) dut (
        .CLK2  (CLK2),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK2 = ~CLK2;

    typedef struct {
        int         cyc;
        logic [7:0] b;
        logic [2:0] xx;
    } fb_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int         m_row = 0;
    int         m_blk = 0;
    logic [7:0] m_col [4];
    fb_t        fbq [$];

    logic        exp_strobeo = 1'b0;
    logic [31:0] exp_data    = '0;
    logic [2:0]  exp_xx      = '0;
    logic [1:0]  exp_row     = '0;
    logic        exp_mbdone  = 1'b0;
    logic        exp_fbs     = 1'b0;
    logic [7:0]  exp_feedbo  = '0;
    logic [2:0]  exp_fbxx    = '0;

    function automatic int recon_pixel(input int base, input int res);
        int s;
        s = base + res;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    function automatic logic [35:0] pack_res(input int r0, input int r1, input int r2, input int r3);
        logic [35:0] p;
        p = {r3[8:0], r2[8:0], r1[8:0], r0[8:0]};
        return p;
    endfunction

    function automatic logic [35:0] rand_res();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return w[35:0];
    endfunction

    // Rows are numbered linearly 0..31 within a line; feedback bytes are scheduled by cycle.
    task automatic model_edge(input bit rst, input bit nl, input bit st,
                              input logic [35:0] d, input logic [31:0] b);
        int lr, lb, lin, px;
        logic [31:0] row;
        fb_t e;
        if (rst) begin
            m_row = 0; m_blk = 0;
            for (int i = 0; i < 4; i++) m_col[i] = '0;
            fbq.delete();
            exp_strobeo = 0; exp_data = '0; exp_xx = '0; exp_row = '0; exp_mbdone = 0;
            exp_feedbo = '0; exp_fbxx = '0;
        end else begin
            exp_strobeo = st;
            exp_mbdone  = 0;
            if (st) begin
                lr = nl ? 0 : m_row;
                lb = nl ? 0 : m_blk;
                row = '0;
                for (int k = 0; k < 4; k++) begin
                    px = recon_pixel(int'(b[8*k +: 8]), int'($signed(d[9*k +: 9])));
                    row[8*k +: 8] = px[7:0];
                end
                exp_data   = row;
                exp_xx     = lb[2:0];
                exp_row    = lr[1:0];
                exp_mbdone = (lb == 7 && lr == 3);
                m_col[lr]  = row[31:24];
                if (lr == 3) begin
                    for (int j = 0; j < 4; j++) begin
                        e.cyc = cyc + 1 + j; e.b = m_col[j]; e.xx = lb[2:0];
                        fbq.push_back(e);
                    end
                end
                lin   = (lb * 4 + lr + 1) % 32;
                m_row = lin % 4;
                m_blk = lin / 4;
            end else if (nl) begin
                m_row = 0; m_blk = 0;
                fbq.delete();
            end
        end
        if (fbq.size() > 0 && fbq[0].cyc == cyc) begin
            exp_fbs = 1; exp_feedbo = fbq[0].b; exp_fbxx = fbq[0].xx;
            void'(fbq.pop_front());
        end else begin
            exp_fbs = 0;
        end
    endtask

    task automatic cycle(input bit rst, input bit nl, input bit st,
                         input logic [35:0] d, input logic [31:0] b);
        RESET       = rst;
        bus.NEWLINE = nl;
        bus.STROBEI = st;
        bus.DATAI   = d;
        bus.BASEI   = b;
        @(posedge CLK2);
        #1;
        cyc++;
        model_edge(rst, nl, st, d, b);
    endtask

    task automatic test_reset();
        cycle(1, 0, 1, rand_res(), $urandom());
        cycle(1, 1, 1, rand_res(), $urandom());
        n_cmp++;
        if ({bus.STROBEO, bus.DATAO, bus.XXO, bus.ROWO, bus.MBDONE} !== 39'd0) begin
            n_err++; $display("[TB] FAIL reset_row_outputs: got %h expected 0",
                              {bus.STROBEO, bus.DATAO, bus.XXO, bus.ROWO, bus.MBDONE});
        end
        n_cmp++;
        if ({bus.FBSTROBE, bus.FEEDBO, bus.FBXX} !== 12'd0) begin
            n_err++; $display("[TB] FAIL reset_fb_outputs: got %h expected 0",
                              {bus.FBSTROBE, bus.FEEDBO, bus.FBXX});
        end
        cycle(0, 0, 0, '0, '0);
        n_cmp++;
        if (bus.STROBEO !== 1'b0) begin
            n_err++; $display("[TB] FAIL reset_idle_strobe: got %b expected 0", bus.STROBEO);
        end
    endtask

    task automatic test_directed_row();
        cycle(0, 1, 0, '0, '0);
        cycle(0, 0, 1, pack_res(5, -3, 0, 127), 32'h80808080);
        n_cmp++;
        if (bus.DATAO !== 32'hFF807D85) begin
            n_err++; $display("[TB] FAIL directed_data: got %h expected ff807d85", bus.DATAO);
        end
        n_cmp++;
        if ({bus.STROBEO, bus.XXO, bus.ROWO} !== {1'b1, 3'd0, 2'd0}) begin
            n_err++; $display("[TB] FAIL directed_label: got strobe=%b xx=%0d row=%0d expected 1/0/0",
                              bus.STROBEO, bus.XXO, bus.ROWO);
        end
        cycle(0, 0, 0, rand_res(), $urandom());
        n_cmp++;
        if ({bus.STROBEO, bus.DATAO, bus.XXO, bus.ROWO} !== {1'b0, 32'hFF807D85, 3'd0, 2'd0}) begin
            n_err++; $display("[TB] FAIL directed_hold: got strobe=%b data=%h expected 0/ff807d85",
                              bus.STROBEO, bus.DATAO);
        end
    endtask

    task automatic test_clipping();
        // Lanes: 0x10-40, 0xF0+40, 0x00-256, 0x55+0; NEWLINE with the row relabels it 0/0.
        cycle(0, 1, 1, pack_res(-40, 40, -256, 0), 32'h5500F010);
        n_cmp++;
        if (bus.DATAO !== 32'h5500FF00) begin
            n_err++; $display("[TB] FAIL clip_data: got %h expected 5500ff00", bus.DATAO);
        end
        n_cmp++;
        if ({bus.XXO, bus.ROWO} !== 5'd0) begin
            n_err++; $display("[TB] FAIL clip_newline_label: got xx=%0d row=%0d expected 0/0", bus.XXO, bus.ROWO);
        end
        cycle(0, 0, 1, rand_res(), $urandom());
        n_cmp++;
        if ({bus.XXO, bus.ROWO, bus.DATAO} !== {3'd0, 2'd1, exp_data}) begin
            n_err++; $display("[TB] FAIL clip_next_row: got xx=%0d row=%0d data=%h expected 0/1/%h",
                              bus.XXO, bus.ROWO, bus.DATAO, exp_data);
        end
    endtask

    task automatic test_feedback();
        logic [31:0] col_bytes;
        logic [35:0] d;
        logic [31:0] b;
        col_bytes = 32'h44332211;
        cycle(0, 1, 0, '0, '0);
        for (int r = 0; r < 4; r++) begin
            d = rand_res(); d[35:27] = 9'd0;
            b = $urandom(); b[31:24] = col_bytes[8*r +: 8];
            cycle(0, 0, 1, d, b);
        end
        // Feedback bytes occupy the four cycles right after the row-3 output cycle.
        for (int j = 1; j <= 6; j++) begin
            cycle(0, 0, 0, rand_res(), $urandom());
            n_cmp++;
            if (bus.FBSTROBE !== (j <= 4)) begin
                n_err++; $display("[TB] FAIL fb_strobe_%0d: got %b expected %b", j, bus.FBSTROBE, (j <= 4));
            end
            if (j <= 4) begin
                n_cmp++;
                if ({bus.FEEDBO, bus.FBXX} !== {col_bytes[8*(j-1) +: 8], 3'd0}) begin
                    n_err++; $display("[TB] FAIL fb_byte_%0d: got %h/%0d expected %h/0",
                                      j, bus.FEEDBO, bus.FBXX, col_bytes[8*(j-1) +: 8]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int mb_cnt, nbytes, first, last;
        mb_cnt = 0; nbytes = 0; first = -1; last = -1;
        cycle(0, 1, 0, '0, '0);
        for (int i = 0; i < 38; i++) begin
            if (i < 32) cycle(0, 0, 1, rand_res(), $urandom());
            else        cycle(0, 0, 0, rand_res(), $urandom());
            if (i < 32) begin
                n_cmp++;
                if ({bus.STROBEO, bus.XXO, bus.ROWO, bus.DATAO} !== {1'b1, 3'(i / 4), 2'(i % 4), exp_data}) begin
                    n_err++; $display("[TB] FAIL b2b_row_%0d: got xx=%0d row=%0d data=%h expected %0d/%0d/%h",
                                      i, bus.XXO, bus.ROWO, bus.DATAO, i / 4, i % 4, exp_data);
                end
            end
            if (bus.MBDONE === 1'b1) mb_cnt++;
            n_cmp++;
            if (bus.MBDONE !== (i == 31)) begin
                n_err++; $display("[TB] FAIL b2b_mbdone_%0d: got %b expected %b", i, bus.MBDONE, (i == 31));
            end
            n_cmp++;
            if (bus.FBSTROBE !== exp_fbs || (exp_fbs && {bus.FEEDBO, bus.FBXX} !== {exp_feedbo, exp_fbxx})) begin
                n_err++; $display("[TB] FAIL b2b_fb_%0d: got %b/%h/%0d expected %b/%h/%0d", i,
                                  bus.FBSTROBE, bus.FEEDBO, bus.FBXX, exp_fbs, exp_feedbo, exp_fbxx);
            end
            if (bus.FBSTROBE === 1'b1) begin
                n_cmp++;
                if (bus.FBXX !== 3'(nbytes / 4)) begin
                    n_err++; $display("[TB] FAIL b2b_fbxx_%0d: got %0d expected %0d", i, bus.FBXX, nbytes / 4);
                end
                if (first < 0) first = i;
                last = i;
                nbytes++;
            end
        end
        n_cmp++;
        if (mb_cnt != 1) begin
            n_err++; $display("[TB] FAIL b2b_mbdone_count: got %0d expected 1", mb_cnt);
        end
        n_cmp++;
        if (nbytes != 32 || (last - first + 1) != 32) begin
            n_err++; $display("[TB] FAIL b2b_fb_span: got %0d bytes over %0d cycles expected 32/32",
                              nbytes, last - first + 1);
        end
    endtask

    task automatic test_newline_abort();
        cycle(0, 1, 0, '0, '0);
        for (int r = 0; r < 4; r++) cycle(0, 0, 1, rand_res(), $urandom());
        for (int j = 0; j < 2; j++) begin
            cycle(0, 0, 0, rand_res(), $urandom());
            n_cmp++;
            if ({bus.FBSTROBE, bus.FEEDBO} !== {1'b1, exp_feedbo}) begin
                n_err++; $display("[TB] FAIL abort_pre_byte_%0d: got %b/%h expected 1/%h",
                                  j, bus.FBSTROBE, bus.FEEDBO, exp_feedbo);
            end
        end
        cycle(0, 1, 0, rand_res(), $urandom());
        n_cmp++;
        if ({bus.FBSTROBE, bus.STROBEO, bus.DATAO} !== {1'b0, 1'b0, exp_data}) begin
            n_err++; $display("[TB] FAIL abort_fb_low: got fb=%b strobe=%b data=%h expected 0/0/%h",
                              bus.FBSTROBE, bus.STROBEO, bus.DATAO, exp_data);
        end
        cycle(0, 0, 0, rand_res(), $urandom());
        n_cmp++;
        if (bus.FBSTROBE !== 1'b0) begin
            n_err++; $display("[TB] FAIL abort_fb_stays_low: got %b expected 0", bus.FBSTROBE);
        end
        cycle(0, 0, 1, rand_res(), $urandom());
        n_cmp++;
        if ({bus.STROBEO, bus.XXO, bus.ROWO} !== {1'b1, 3'd0, 2'd0}) begin
            n_err++; $display("[TB] FAIL abort_next_label: got %b/%0d/%0d expected 1/0/0",
                              bus.STROBEO, bus.XXO, bus.ROWO);
        end
    endtask

    task automatic test_reset_mid_block();
        cycle(0, 1, 0, '0, '0);
        for (int r = 0; r < 5; r++) cycle(0, 0, 1, rand_res(), $urandom());
        cycle(1, 0, 1, rand_res(), $urandom());
        n_cmp++;
        if ({bus.STROBEO, bus.DATAO, bus.XXO, bus.ROWO, bus.MBDONE, bus.FBSTROBE, bus.FEEDBO, bus.FBXX} !== 51'd0) begin
            n_err++; $display("[TB] FAIL midreset_outputs: got %h expected 0",
                              {bus.STROBEO, bus.DATAO, bus.XXO, bus.ROWO, bus.MBDONE, bus.FBSTROBE, bus.FEEDBO, bus.FBXX});
        end
        cycle(0, 0, 0, rand_res(), $urandom());
        n_cmp++;
        if (bus.FBSTROBE !== 1'b0) begin
            n_err++; $display("[TB] FAIL midreset_drain_aborted: got %b expected 0", bus.FBSTROBE);
        end
        cycle(0, 0, 1, rand_res(), $urandom());
        n_cmp++;
        if ({bus.STROBEO, bus.XXO, bus.ROWO, bus.DATAO} !== {1'b1, 3'd0, 2'd0, exp_data}) begin
            n_err++; $display("[TB] FAIL midreset_first_row: got %b/%0d/%0d/%h expected 1/0/0/%h",
                              bus.STROBEO, bus.XXO, bus.ROWO, bus.DATAO, exp_data);
        end
    endtask

    task automatic test_random();
        bit st, nl;
        for (int i = 0; i < 300; i++) begin
            st = ($urandom_range(3, 0) != 0);
            nl = ($urandom_range(40, 0) == 0);
            cycle(0, nl, st, rand_res(), $urandom());
            n_cmp++;
            if ({bus.STROBEO, bus.DATAO, bus.XXO, bus.ROWO, bus.MBDONE} !==
                {exp_strobeo, exp_data, exp_xx, exp_row, exp_mbdone}) begin
                n_err++; $display("[TB] FAIL rand_row_%0d: got %b/%h/%0d/%0d/%b expected %b/%h/%0d/%0d/%b", i,
                                  bus.STROBEO, bus.DATAO, bus.XXO, bus.ROWO, bus.MBDONE,
                                  exp_strobeo, exp_data, exp_xx, exp_row, exp_mbdone);
            end
            n_cmp++;
            if (bus.FBSTROBE !== exp_fbs || (exp_fbs && {bus.FEEDBO, bus.FBXX} !== {exp_feedbo, exp_fbxx})) begin
                n_err++; $display("[TB] FAIL rand_fb_%0d: got %b/%h/%0d expected %b/%h/%0d", i,
                                  bus.FBSTROBE, bus.FEEDBO, bus.FBXX, exp_fbs, exp_feedbo, exp_fbxx);
            end
        end
    endtask

    initial begin
        RESET       = 1'b1;
        bus.NEWLINE = 1'b0;
        bus.STROBEI = 1'b0;
        bus.DATAI   = '0;
        bus.BASEI   = '0;
        for (int i = 0; i < 4; i++) m_col[i] = '0;
        test_reset();
        test_directed_row();
        test_clipping();
        test_feedback();
        test_back_to_back();
        test_newline_abort();
        test_reset_mid_block();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
